// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over req/ack and
// feeds IF/ID through a one-entry output slot backed by a skid buffer.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h00400000,
  parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_plus_4_out,
  output logic        fetch_valid
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    DROP
  } state_t;

  state_t      state;
  logic [31:0] req_addr;
  logic [31:0] pending_target;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc4;
  logic        skid_valid;

  logic        slot_free;
  logic [31:0] tgt;
  logic [31:0] addr_inc;

  assign slot_free = !fetch_valid || !stall_in;
  assign tgt       = redirect_target & ~32'h3;
  assign addr_inc  = req_addr + 32'd4;
  assign imem_addr = req_addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      req_addr        <= RESET_PC;
      pending_target  <= '0;
      imem_req        <= 1'b0;
      fetch_valid     <= 1'b0;
      instruction_out <= NOP_INSTR;
      pc_plus_4_out   <= '0;
      skid_instr      <= '0;
      skid_pc4        <= '0;
      skid_valid      <= 1'b0;
    end else if (redirect_valid) begin
      // squash everything younger than the branch
      fetch_valid     <= 1'b0;
      instruction_out <= NOP_INSTR;
      skid_valid      <= 1'b0;
      imem_req        <= 1'b1;
      unique case (state)
        REQ: begin
          if (imem_ack) begin
            req_addr <= tgt;
          end else begin
            pending_target <= tgt;
            state          <= DROP;
          end
        end
        DROP: begin
          pending_target <= tgt;
          if (imem_ack) begin
            req_addr <= tgt;
            state    <= REQ;
          end
        end
        default: begin
          req_addr <= tgt;
          state    <= REQ;
        end
      endcase
    end else begin
      if (slot_free) fetch_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end
        REQ: begin
          if (imem_ack) begin
            req_addr <= addr_inc;
            if (slot_free) begin
              fetch_valid     <= 1'b1;
              instruction_out <= imem_rdata;
              pc_plus_4_out   <= addr_inc;
            end else begin
              skid_instr <= imem_rdata;
              skid_pc4   <= addr_inc;
              skid_valid <= 1'b1;
              state      <= HOLD;
              imem_req   <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (slot_free) begin
            fetch_valid     <= skid_valid;
            instruction_out <= skid_instr;
            pc_plus_4_out   <= skid_pc4;
            skid_valid      <= 1'b0;
            state           <= REQ;
            imem_req        <= 1'b1;
          end
        end
        DROP: begin
          // stale word from before the redirect is thrown away
          if (imem_ack) begin
            req_addr <= pending_target;
            state    <= REQ;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: latency-programmable memory,
// in-order delivery scoreboard and directed scenarios.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall_in = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic [31:0] instruction_out;
  logic [31:0] pc_plus_4_out;
  logic        fetch_valid;

  int checks = 0;
  int errors = 0;
  int lat = 0;
  int cnt = 0;

  instruction_fetch_unit dut (
    .clk(clk),
    .reset(reset),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .stall_in(stall_in),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .instruction_out(instruction_out),
    .pc_plus_4_out(pc_plus_4_out),
    .fetch_valid(fetch_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return ~a;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // memory: ack after lat wait cycles, may ack in the request cycle
  always @(posedge clk) begin
    #1;
    if (!reset || !imem_req) begin
      imem_ack = 1'b0;
      cnt = 0;
    end else if (cnt >= lat) begin
      imem_ack = 1'b1;
      imem_rdata = mem(imem_addr);
      cnt = 0;
    end else begin
      imem_ack = 1'b0;
      imem_rdata = 32'hDEADBEEF;
      cnt++;
    end
  end

  // scoreboard: sequential stream from the last redirect target
  logic [31:0] exp_pc = 32'h00400000;
  logic        redir_chk = 1'b0;
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic [31:0] prev_addr = '0;

  always @(negedge clk) begin
    if (!reset) begin
      exp_pc = 32'h00400000;
      redir_chk = 1'b0;
      prev_req = 1'b0;
    end else begin
      if (redir_chk) begin
        chk("squash_valid", {31'b0, fetch_valid}, 32'd0);
        chk("squash_nop", instruction_out, 32'h0);
      end
      if (prev_req && !prev_ack) begin
        chk("req_held", {31'b0, imem_req}, 32'd1);
        chk("addr_stable", imem_addr, prev_addr);
      end
      if (redirect_valid) begin
        exp_pc = redirect_target & ~32'h3;
        redir_chk = 1'b1;
      end else begin
        redir_chk = 1'b0;
        if (fetch_valid && !stall_in) begin
          chk("deliver_instr", instruction_out, mem(exp_pc));
          chk("deliver_pc4", pc_plus_4_out, exp_pc + 32'd4);
          exp_pc = exp_pc + 32'd4;
        end
      end
      prev_req = imem_req;
      prev_ack = imem_ack;
      prev_addr = imem_addr;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int l);
    reset = 1'b0;
    stall_in = 1'b0;
    redirect_valid = 1'b0;
    lat = l;
    step();
    step();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, fetch_valid}, 32'd0);
    chk("rst_instr", instruction_out, 32'h0);
    chk("rst_pc4", pc_plus_4_out, 32'h0);
    chk("rst_addr", imem_addr, 32'h00400000);
    reset = 1'b1;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!fetch_valid && n < 20) begin
      step();
      n++;
    end
    chk(nm, {31'b0, fetch_valid}, 32'd1);
  endtask

  task automatic wait_addr_leave(input logic [31:0] a, input string nm);
    int n = 0;
    while (imem_addr == a && n < 12) begin
      chk({nm, "_novalid"}, {31'b0, fetch_valid}, 32'd0);
      step();
      n++;
    end
  endtask

  task automatic redirect(input logic [31:0] t);
    redirect_valid = 1'b1;
    redirect_target = t;
    step();
    redirect_valid = 1'b0;
  endtask

  logic [31:0] p;

  initial begin
    // zero-wait streaming
    do_reset(0);
    step();
    chk("t1_addr0", imem_addr, 32'h00400000);
    chk("t1_req", {31'b0, imem_req}, 32'd1);
    chk("t1_v0", {31'b0, fetch_valid}, 32'd0);
    step();
    chk("t1_v1", {31'b0, fetch_valid}, 32'd1);
    chk("t1_pc4a", pc_plus_4_out, 32'h00400004);
    chk("t1_ins_a", instruction_out, 32'hFFBFFFFF);
    chk("t1_addr1", imem_addr, 32'h00400004);
    step();
    chk("t1_pc4b", pc_plus_4_out, 32'h00400008);
    chk("t1_ins_b", instruction_out, 32'hFFBFFFFB);
    chk("t1_addr2", imem_addr, 32'h00400008);
    step();
    step();

    // stall three cycles while data keeps arriving
    p = pc_plus_4_out;
    stall_in = 1'b1;
    step();
    chk("t2_req_off", {31'b0, imem_req}, 32'd0);
    chk("t2_frozen", pc_plus_4_out, p);
    step();
    step();
    chk("t2_frozen3", pc_plus_4_out, p);
    chk("t2_valid", {31'b0, fetch_valid}, 32'd1);
    stall_in = 1'b0;
    step();
    chk("t2_skid", pc_plus_4_out, p + 32'd4);
    chk("t2_skid_v", {31'b0, fetch_valid}, 32'd1);
    step();
    chk("t2_after", pc_plus_4_out, p + 32'd8);
    step();

    // redirect with ack and stall while slot is valid
    chk("t4_pre_v", {31'b0, fetch_valid}, 32'd1);
    stall_in = 1'b1;
    redirect(32'h00400200);
    stall_in = 1'b0;
    chk("t4_v0", {31'b0, fetch_valid}, 32'd0);
    chk("t4_nop", instruction_out, 32'h0);
    chk("t4_addr", imem_addr, 32'h00400200);
    wait_valid("t4_wait");
    chk("t4_pc4", pc_plus_4_out, 32'h00400204);
    step();

    // PC wrap and misaligned target
    redirect(32'hFFFFFFFC);
    chk("t6_addr", imem_addr, 32'hFFFFFFFC);
    step();
    chk("t6_pc4", pc_plus_4_out, 32'h00000000);
    chk("t6_next", imem_addr, 32'h00000000);
    step();
    chk("t6_pc4b", pc_plus_4_out, 32'h00000004);
    redirect(32'h00400303);
    chk("t6_align", imem_addr, 32'h00400300);
    step();
    step();

    // redirect in first wait cycle of a 3-cycle fetch
    do_reset(3);
    step();
    chk("t3_req", {31'b0, imem_req}, 32'd1);
    redirect(32'h00400100);
    chk("t3_drop_addr", imem_addr, 32'h00400000);
    chk("t3_drop_req", {31'b0, imem_req}, 32'd1);
    wait_addr_leave(32'h00400000, "t3");
    chk("t3_new_addr", imem_addr, 32'h00400100);
    wait_valid("t3_wait");
    chk("t3_pc4", pc_plus_4_out, 32'h00400104);

    // two redirects inside one DROP
    do_reset(3);
    step();
    redirect(32'h00000100);
    redirect_valid = 1'b1;
    redirect_target = 32'h00000200;
    step();
    redirect_valid = 1'b0;
    wait_addr_leave(32'h00400000, "t5");
    chk("t5_addr", imem_addr, 32'h00000200);
    wait_valid("t5_wait");
    chk("t5_pc4", pc_plus_4_out, 32'h00000204);

    // asynchronous reset in the middle of a request
    step();
    chk("t7_busy", {31'b0, imem_req}, 32'd1);
    reset = 1'b0;
    #1;
    chk("t7_req", {31'b0, imem_req}, 32'd0);
    chk("t7_valid", {31'b0, fetch_valid}, 32'd0);
    chk("t7_instr", instruction_out, 32'h0);
    chk("t7_pc4", pc_plus_4_out, 32'h0);
    chk("t7_addr", imem_addr, 32'h00400000);
    step();
    reset = 1'b1;
    wait_valid("t7_wait");
    chk("t7_first", pc_plus_4_out, 32'h00400004);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
